// File: rtl/ser2par_bus.sv
// ser2par_bus: frames a qualified serial bit stream into WIDTH-bit words on a valid/ready bus.
// Build option PARITY_CHECK_EN adds a trailing even-parity bit per word and drives parity_err.
module ser2par_bus #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             d,
  input  logic             d_vld,
  input  logic             frame,
  output logic [WIDTH-1:0] bus,
  output logic             bus_vld,
  input  logic             bus_rdy,
  output logic             ovf,
  output logic             sync_err,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, HOLD} state_t;
`ifdef PARITY_CHECK_EN
  localparam state_t LAST_ST = PAR;
`else
  localparam state_t LAST_ST = HOLD;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, bus_q, bus_d, sr_shift, sr_fresh;
  logic bus_vld_q, bus_vld_d, ovf_q, ovf_d, sync_err_q, sync_err_d;
  logic start, data_bit, xfer, last_bit;
  assign start    = d_vld & frame;
  assign data_bit = d_vld & ~frame;
  assign xfer     = bus_vld_q & bus_rdy;
  assign last_bit = cnt_q == CW'(WIDTH - 1);
  // the first serial bit migrates to bus[WIDTH-1] (MSB first) or bus[0] (LSB first)
  assign sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], d} : {d, sr_q[WIDTH-1:1]};
  assign sr_fresh = MSB_FIRST ? {{(WIDTH-1){1'b0}}, d} : {d, {(WIDTH-1){1'b0}}};
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SHIFT : IDLE;
      SHIFT:   state_d = data_bit && last_bit ? LAST_ST : SHIFT;
      PAR:     state_d = data_bit ? HOLD : start ? SHIFT : PAR;
      HOLD:    state_d = !xfer ? HOLD : start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    bus_d      = bus_q;
    bus_vld_d  = bus_vld_q;
    ovf_d      = 1'b0;
    sync_err_d = 1'b0;
    case (state_q)
      IDLE:
        if (start) begin
          sr_d  = sr_fresh;
          cnt_d = CW'(1);
        end
      SHIFT, PAR:
        if (start) begin
          sr_d       = sr_fresh;
          cnt_d      = CW'(1);
          sync_err_d = 1'b1;
        end else if (data_bit) begin
          sr_d  = state_q == SHIFT ? sr_shift : sr_q;
          cnt_d = cnt_q + CW'(1);
          if (state_q == PAR || (last_bit && LAST_ST == HOLD)) begin
            bus_d     = sr_d;
            bus_vld_d = 1'b1;
            cnt_d     = '0;
          end
        end
      HOLD: begin
        ovf_d     = d_vld & ~(xfer & frame);
        bus_vld_d = ~xfer;
        if (xfer && start) begin
          sr_d  = sr_fresh;
          cnt_d = CW'(1);
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      bus_q      <= '0;
      bus_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      bus_q      <= bus_d;
      bus_vld_q  <= bus_vld_d;
      ovf_q      <= ovf_d;
      sync_err_q <= sync_err_d;
    end
`ifdef PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;
  always_comb parity_err_d = state_q == PAR && data_bit ? ^{sr_q, d} : xfer ? 1'b0 : parity_err_q;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) parity_err_q <= 1'b0;
    else parity_err_q <= parity_err_d;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
  assign bus      = bus_q;
  assign bus_vld  = bus_vld_q;
  assign ovf      = ovf_q;
  assign sync_err = sync_err_q;
endmodule
